r_route_ctrl: RTL

R_ROUTE_CTRL -- requirements
Module: r_route_ctrl

---
 rtl/r_route_ctrl_pkg.sv | 15 +
 rtl/r_route_ctrl_if.sv | 31 +++
 rtl/r_route_ctrl_idx_fifo.sv | 61 ++++++
 rtl/r_route_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/r_route_ctrl_pkg.sv
// Shared interconnect constants and the read-route tracker state encoding.
// Imported by the R-channel routing controller and its interface.
package r_route_ctrl_pkg;

    localparam int NUM_MASTERS = 6;
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_IDLE = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

endpackage

// File: rtl/r_route_ctrl_if.sv
// AR/R routing signals between the interconnect fabric and r_route_ctrl.
// "slave" is the controller's view; "master" is the fabric driving it.
interface r_route_ctrl_if #(
    parameter int BEAT_W = 8
);
    import r_route_ctrl_pkg::*;

    logic                   ar_fire;
    logic [SEL_W-1:0]       ar_idx;
    logic                   ar_stall;
    logic                   s_rvalid;
    logic                   s_rlast;
    logic                   s_rready;
    logic [NUM_MASTERS-1:0] m_rready;
    logic [SEL_W-1:0]       r_sel;
    logic                   r_valid_o;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [4:0]             outstanding;
    logic                   err_o;

    modport slave (
        input  ar_fire, ar_idx, s_rvalid, s_rlast, m_rready,
        output ar_stall, s_rready, r_sel, r_valid_o, beat_cnt, outstanding, err_o
    );

    modport master (
        output ar_fire, ar_idx, s_rvalid, s_rlast, m_rready,
        input  ar_stall, s_rready, r_sel, r_valid_o, beat_cnt, outstanding, err_o
    );

endinterface

// File: rtl/r_route_ctrl_idx_fifo.sv
// FIFO of master indices for outstanding read bursts, in AR issue order.
// Head is read combinationally so routing adds no latency.
module idx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [4:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [4:0]       count_reg;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == 5'(DEPTH));
    assign empty   = (count_reg == 5'd0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Storage is not reset: entries are only observable when count says so.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 5'd1;
                2'b01:   count_reg <= count_reg - 5'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/r_route_ctrl.sv
// Tracks outstanding read bursts and steers slave R beats to the owning
// master, in AR order; flags protocol violations in a sticky error bit.
module r_route_ctrl
    import r_route_ctrl_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int BEAT_W = 8
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    r_route_ctrl_if.slave bus
);

    state_t            state_reg;
    state_t            state_next;
    logic [BEAT_W-1:0] beat_cnt_reg;
    logic              err_reg;

    logic [SEL_W-1:0]  head;
    logic [4:0]        count;
    logic [4:0]        count_after;
    logic [7:0]        rready_vec;
    logic              full;
    logic              empty;
    logic              idx_ok;
    logic              push_ok;
    logic              beat_ok;
    logic              pop;
    logic              err_set;

    assign full    = (count == 5'(DEPTH));
    assign empty   = (count == 5'd0);
    assign idx_ok  = (bus.ar_idx <= SEL_W'(NUM_MASTERS - 1));
    assign push_ok = bus.ar_fire & ~full & idx_ok;

    // Padded so a head index is always in range of the ready vector.
    assign rready_vec = {{(8 - NUM_MASTERS){1'b0}}, bus.m_rready};

    assign bus.s_rready  = ~empty & rready_vec[head];
    assign bus.r_sel     = empty ? SEL_IDLE : head;
    assign bus.r_valid_o = bus.s_rvalid & ~empty;
    assign bus.ar_stall  = full;

    assign beat_ok     = bus.s_rvalid & bus.s_rready;
    assign pop         = beat_ok & bus.s_rlast;
    assign err_set     = (bus.ar_fire & (full | ~idx_ok)) | (bus.s_rvalid & empty);
    assign count_after = count + 5'(push_ok) - 5'(pop);

    idx_fifo #(
        .DEPTH (DEPTH),
        .W     (SEL_W)
    ) u_idx_fifo (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .push      (push_ok),
        .push_data (bus.ar_idx),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (push_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT, BURST: begin
                if (pop) begin
                    state_next = (count_after == 5'd0) ? IDLE : WAIT;
                end else if (beat_ok) begin
                    state_next = BURST;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            beat_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (beat_ok) begin
                if (bus.s_rlast) begin
                    beat_cnt_reg <= '0;
                end else if (~&beat_cnt_reg) begin
                    beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
                end
            end
            if (err_set) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.beat_cnt    = beat_cnt_reg;
    assign bus.outstanding = count;
    assign bus.err_o       = err_reg;

endmodule
